// File: rtl/ssd_scan_capture.sv
// Purpose: loopback monitor that rebuilds a 16-bit hex word from the multiplexed 4-digit SSD bus.
// Latency: captures a vector STABLE_CYCLES+1 edges after it is first sampled; outputs registered on that capture edge.
// Backpressure: none; a passive observer that never stalls the bus it watches.
//
// Ports:
//   ClkPort, Reset_n : system clock, asynchronous active-low reset
//   an_n[3:0]        : anode lines, bit i = digit i, active-low
//   cath_n[7:0]      : {a,b,c,d,e,f,g,Dp}, active-low
//   digits[15:0]     : last complete frame {digit3,digit2,digit1,digit0}
//   dp[3:0]          : decimal points of the last frame, 1 = lit
//   frame_valid      : one-cycle pulse when digits/dp update
//   anode_err        : one-cycle pulse, stable anode vector had several active anodes
//   pattern_err      : one-cycle pulse, stable segment pattern was not a hex glyph
//   err_sticky[1:0]  : {pattern, anode} error seen since reset
module ssd_scan_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        ClkPort,
    input  logic        Reset_n,
    input  logic [3:0]  an_n,
    input  logic [7:0]  cath_n,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        anode_err,
    output logic        pattern_err,
    output logic [1:0]  err_sticky
);

    localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] CNT_MAX  = 16'(STABLE_CYCLES);

    // Two-flop synchronizer; resets to the idle bus (everything dark).
    logic [11:0] sync_meta;
    logic [11:0] sync_q;

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_meta <= '1;
            sync_q    <= '1;
        end else begin
            sync_meta <= {an_n, cath_n};
            sync_q    <= sync_meta;
        end
    end

    // The vector about to enter sync_q is compared with the one it replaces,
    // so the count restarts on the same edge the new vector appears at the
    // synchronizer output. A metastable resolution in the first stage can only
    // restart the count, never produce a capture.
    logic        vec_match;
    logic [15:0] cnt;
    logic        strobe;

    assign vec_match = (sync_meta == sync_q);
    assign strobe    = vec_match && (cnt == CNT_LAST);

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (!vec_match) begin
            cnt <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 16'd1;
        end
    end

    // abcdefg (active-low) to {legal, nibble}.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [3:0]  an_cur;
    logic        an_one;
    logic        an_bad;
    logic [1:0]  dig_idx;
    logic        glyph_ok;
    logic [3:0]  glyph_nib;
    logic [3:0]  seen;
    logic [15:0] shadow;
    logic [3:0]  dp_shadow;
    logic [15:0] shadow_upd;
    logic [3:0]  dp_upd;
    logic [3:0]  seen_upd;

    assign an_cur                = sync_q[11:8];
    assign {glyph_ok, glyph_nib} = glyph_decode(sync_q[7:1]);

    always_comb begin
        an_one  = 1'b0;
        an_bad  = 1'b0;
        dig_idx = 2'd0;
        case (an_cur)
            4'b1111: ;                              // blanked bus
            4'b1110: begin an_one = 1'b1; dig_idx = 2'd0; end
            4'b1101: begin an_one = 1'b1; dig_idx = 2'd1; end
            4'b1011: begin an_one = 1'b1; dig_idx = 2'd2; end
            4'b0111: begin an_one = 1'b1; dig_idx = 2'd3; end
            default: an_bad = 1'b1;
        endcase
    end

    // Shadow contents as they would be with the current capture applied, so a
    // completing capture can publish its own digit on the same edge.
    always_comb begin
        shadow_upd                        = shadow;
        dp_upd                            = dp_shadow;
        seen_upd                          = seen;
        shadow_upd[{dig_idx, 2'b00} +: 4] = glyph_nib;
        dp_upd[dig_idx]                   = ~sync_q[0];
        seen_upd[dig_idx]                 = 1'b1;
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            seen        <= '0;
            shadow      <= '0;
            dp_shadow   <= '0;
            digits      <= '0;
            dp          <= '0;
            frame_valid <= 1'b0;
            anode_err   <= 1'b0;
            pattern_err <= 1'b0;
            err_sticky  <= '0;
        end else begin
            frame_valid <= 1'b0;
            anode_err   <= 1'b0;
            pattern_err <= 1'b0;
            if (strobe) begin
                if (an_bad) begin
                    anode_err     <= 1'b1;
                    err_sticky[0] <= 1'b1;
                    seen          <= '0;
                end else if (an_one) begin
                    if (!glyph_ok) begin
                        pattern_err   <= 1'b1;
                        err_sticky[1] <= 1'b1;
                        seen          <= '0;
                    end else begin
                        shadow    <= shadow_upd;
                        dp_shadow <= dp_upd;
                        if (seen_upd == 4'b1111) begin
                            digits      <= shadow_upd;
                            dp          <= dp_upd;
                            frame_valid <= 1'b1;
                            seen        <= '0;
                        end else begin
                            seen <= seen_upd;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_capture.sv
module tb_ssd_scan_capture;

    localparam int SC = 16;

    logic        ClkPort = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  an_n    = 4'hF;
    logic [7:0]  cath_n  = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        anode_err;
    logic        pattern_err;
    logic [1:0]  err_sticky;

    ssd_scan_capture #(.STABLE_CYCLES(SC)) dut (
        .ClkPort     (ClkPort),
        .Reset_n     (Reset_n),
        .an_n        (an_n),
        .cath_n      (cath_n),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .anode_err   (anode_err),
        .pattern_err (pattern_err),
        .err_sticky  (err_sticky)
    );

    always #5 ClkPort = ~ClkPort;

    int unsigned cyc = 0;
    always @(posedge ClkPort) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int ae_cnt   = 0;
    int pe_cnt   = 0;

    logic [15:0] exp_dig_q[$];
    logic [3:0]  exp_dp_q[$];
    int unsigned exp_cyc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Scoreboard side: every frame_valid must match the oldest expected frame.
    always @(negedge ClkPort) begin
        if (Reset_n) begin
            if (frame_valid || anode_err || pattern_err)
                check("pulse_excl", $countones({frame_valid, anode_err, pattern_err}), 1);
            if (anode_err)   ae_cnt++;
            if (pattern_err) pe_cnt++;
            if (frame_valid) begin
                fv_cnt++;
                if (exp_dig_q.size() == 0) begin
                    check("frame_unexpected", exp_dig_q.size(), 1);
                end else begin
                    check("frame_digits", digits, exp_dig_q[0]);
                    check("frame_dp", dp, exp_dp_q[0]);
                    if (exp_cyc_q[0] != 0) check("frame_cycle", cyc, exp_cyc_q[0]);
                    void'(exp_dig_q.pop_front());
                    void'(exp_dp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    // All drive tasks start and end on a falling edge.
    task automatic hold(input logic [3:0] an, input logic [7:0] cath, input int n);
        an_n   = an;
        cath_n = cath;
        repeat (n) @(negedge ClkPort);
    endtask

    task automatic put_digit(input int i, input logic [3:0] nib, input logic dp_line, input int n);
        hold(4'(~(4'b0001 << i)), {seg_of(nib), dp_line}, n);
    endtask

    // Pin change at this falling edge is sampled at the next rising edge E;
    // capture lands on E+1+SC, observed on the falling edge that follows.
    task automatic expect_frame(input logic [15:0] d, input logic [3:0] dp_lit);
        exp_dig_q.push_back(d);
        exp_dp_q.push_back(dp_lit);
        exp_cyc_q.push_back(cyc + SC + 2);
    endtask

    task automatic scan(input logic [15:0] word, input logic [3:0] dp_line);
        for (int i = 0; i < 3; i++) put_digit(i, word[4*i +: 4], dp_line[i], 100);
        expect_frame(word, ~dp_line);
        put_digit(3, word[15:12], dp_line[3], 100);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        @(negedge ClkPort);

        // Reset held with a busy bus, then a long idle period.
        repeat (20) begin
            an_n   = 4'($urandom);
            cath_n = 8'($urandom);
            @(negedge ClkPort);
        end
        check("rst_digits", digits, 0);
        check("rst_dp", dp, 0);
        check("rst_pulses", {frame_valid, anode_err, pattern_err}, 0);
        check("rst_sticky", err_sticky, 0);
        an_n    = 4'hF;
        cath_n  = 8'hFF;
        Reset_n = 1'b1;
        repeat (1000) @(negedge ClkPort);
        check("idle_pulses", fv_cnt + ae_cnt + pe_cnt, 0);
        check("idle_sticky", err_sticky, 0);

        // Nominal scan, two sweeps, all decimal points lit.
        scan(16'h0A3C, 4'b0000);
        scan(16'h0A3C, 4'b0000);
        check("nom_digits", digits, 16'h0A3C);
        check("nom_dp", dp, 4'b1111);
        check("nom_frames", fv_cnt, 2);

        // Glitch of 8 inside a stable 5 on digit 1.
        put_digit(0, 4'h1, 1'b1, 100);
        put_digit(1, 4'h5, 1'b1, 40);
        put_digit(1, 4'h8, 1'b1, 10);
        put_digit(1, 4'h5, 1'b1, 50);
        put_digit(2, 4'h3, 1'b1, 100);
        expect_frame(16'h4351, 4'b0000);
        put_digit(3, 4'h4, 1'b1, 100);
        check("glitch_digits", digits, 16'h4351);
        check("glitch_errs", ae_cnt + pe_cnt, 0);

        // Anode fault mid-frame discards digits 0..2 already seen.
        put_digit(0, 4'h9, 1'b1, 100);
        put_digit(1, 4'h9, 1'b1, 100);
        put_digit(2, 4'h9, 1'b1, 100);
        base = ae_cnt;
        hold(4'b1100, {seg_of(4'h8), 1'b1}, 50);
        check("anode_err_cnt", ae_cnt - base, 1);
        check("anode_sticky", err_sticky, 2'b01);
        put_digit(3, 4'hB, 1'b1, 100);
        put_digit(0, 4'h1, 1'b1, 100);
        put_digit(1, 4'h2, 1'b0, 100);
        expect_frame(16'hB321, 4'b0010);
        put_digit(2, 4'h3, 1'b1, 100);
        check("anode_frame", digits, 16'hB321);

        // Blank glyph on an active digit.
        base = pe_cnt;
        hold(4'b1110, 8'hFF, 50);
        check("pattern_err_cnt", pe_cnt - base, 1);
        check("pattern_sticky", err_sticky, 2'b11);
        check("pattern_digits", digits, 16'hB321);

        // Reset after a partial frame.
        put_digit(0, 4'h7, 1'b1, 100);
        put_digit(1, 4'h7, 1'b1, 100);
        an_n    = 4'hF;
        cath_n  = 8'hFF;
        Reset_n = 1'b0;
        repeat (3) @(negedge ClkPort);
        check("mid_rst_digits", digits, 0);
        check("mid_rst_sticky", err_sticky, 0);
        Reset_n = 1'b1;
        @(negedge ClkPort);
        base = fv_cnt;
        scan(16'h1234, 4'b0101);
        repeat (50) @(negedge ClkPort);
        check("mid_rst_frames", fv_cnt - base, 1);
        check("mid_rst_digits2", digits, 16'h1234);
        check("mid_rst_dp", dp, 4'b1010);

        check("frames_left", exp_dig_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
